// File: rtl/matvec_mac_engine.sv
// Matrix-vector multiply engine: y = W*x over a column-organised weight RAM.
// One column per cycle feeds NROW parallel signed MAC lanes; results are rescaled and saturated.
module matvec_mac_engine #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int FRAC          = 11,
  parameter int ADDR_BITWIDTH = $clog2(NCOL),
  parameter int ACC_W         = 2*BITWIDTH + ADDR_BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BITWIDTH*NCOL-1:0]     xIn,
  output logic [ADDR_BITWIDTH-1:0]     weightAddr,
  input  logic [BITWIDTH*NROW-1:0]     weightRow,
  output logic                         busy,
  output logic [BITWIDTH*NROW-1:0]     yOut,
  output logic                         done
);

  localparam int PROD_W = 2*BITWIDTH;
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((1 <<< (BITWIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = -YMAX - ACC_W'(1);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL-1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OUT
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_BITWIDTH-1:0]        colCnt_q, colCnt_d;
  logic [ADDR_BITWIDTH-1:0]        addr_q, addr_d;
  logic signed [BITWIDTH-1:0]      xVec_q [NCOL];
  logic signed [BITWIDTH-1:0]      xVec_d [NCOL];
  logic signed [ACC_W-1:0]         acc_q [NROW];
  logic signed [ACC_W-1:0]         acc_d [NROW];
  logic [BITWIDTH*NROW-1:0]        yOut_q, yOut_d;
  logic                            done_q, done_d;

  logic signed [BITWIDTH-1:0]      xSel;
  logic signed [PROD_W-1:0]        prod [NROW];
  logic signed [ACC_W-1:0]         scaled [NROW];
  logic                            lastCol;

  // Clamp a rescaled accumulator into the datapath word range.
  function automatic logic [BITWIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > YMAX) begin
      return BITWIDTH'(YMAX);
    end else if (v < YMIN) begin
      return BITWIDTH'(YMIN);
    end
    return v[BITWIDTH-1:0];
  endfunction

  assign lastCol    = (colCnt_q == LAST_COL);
  assign weightAddr = addr_q;
  assign yOut       = yOut_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (lastCol) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    colCnt_d = colCnt_q;
    addr_d   = addr_q;
    xVec_d   = xVec_q;
    acc_d    = acc_q;
    yOut_d   = yOut_q;
    done_d   = 1'b0;

    // weightRow already holds the column for colCnt_q: the address was registered one edge earlier.
    xSel = xVec_q[colCnt_q];
    for (int i = 0; i < NROW; i++) begin
      prod[i]   = PROD_W'($signed(weightRow[i*BITWIDTH +: BITWIDTH])) * PROD_W'(xSel);
      scaled[i] = acc_q[i] >>> FRAC;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int j = 0; j < NCOL; j++) begin
            xVec_d[j] = $signed(xIn[j*BITWIDTH +: BITWIDTH]);
          end
          for (int i = 0; i < NROW; i++) begin
            acc_d[i] = '0;
          end
          colCnt_d = '0;
          addr_d   = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NROW; i++) begin
          acc_d[i] = acc_q[i] + ACC_W'(prod[i]);
        end
        if (!lastCol) begin
          colCnt_d = colCnt_q + 1'b1;
          addr_d   = colCnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        for (int i = 0; i < NROW; i++) begin
          yOut_d[i*BITWIDTH +: BITWIDTH] = sat(scaled[i]);
        end
        done_d = 1'b1;
        addr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      colCnt_q <= '0;
      addr_q   <= '0;
      yOut_q   <= '0;
      done_q   <= 1'b0;
      for (int j = 0; j < NCOL; j++) begin
        xVec_q[j] <= '0;
      end
      for (int i = 0; i < NROW; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      colCnt_q <= colCnt_d;
      addr_q   <= addr_d;
      yOut_q   <= yOut_d;
      done_q   <= done_d;
      xVec_q   <= xVec_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: doc/matvec_mac_engine.md
Name: matvec_mac_engine

Overview:
- Downstream consumer of the column-organised weight RAM in the dot_prod datapath.
- Computes y = W·x for an NROW×NCOL signed fixed-point matrix W against an NCOL-element input vector x.
- Sweeps the RAM read address over all NCOL columns and multiplies each returned column (NROW words) by the matching x element. Results are accumulated in NROW parallel MACs, then rescaled and saturated to the datapath word width.
- Feeds the activation/gate stage of the RNN cell.

Parameters:
- NROW, 16, matrix rows = parallel MAC lanes = output vector length
- NCOL, 16, matrix columns = input vector length = RAM depth (power of 2)
- BITWIDTH, 18, signed two's-complement word width of W, x, y
- FRAC, 11, fractional bits of the fixed-point format (1.0 = 2^FRAC)
- ADDR_BITWIDTH, log2(NCOL), width of the column address
- ACC_W, 2*BITWIDTH+ADDR_BITWIDTH, accumulator width (no internal overflow possible)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- xIn  in  BITWIDTH*NCOL  input vector, element j at [j*BITWIDTH +: BITWIDTH]; latched at accepted start
- weightAddr  out  ADDR_BITWIDTH  column read address to weight RAM
- weightRow  in  BITWIDTH*NROW  column returned by RAM, row i at [i*BITWIDTH +: BITWIDTH]
- busy  out  1  high while a multiply is in progress; weight RAM write enable must be held low while high
- yOut  out  BITWIDTH*NROW  result vector, row i at [i*BITWIDTH +: BITWIDTH]; held until next done
- done  out  1  one-cycle pulse: yOut updated this cycle

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0; done=0; weightAddr=0; yOut=0; accumulators=0; column counter=0.
- RAM timing contract: the column for the weightAddr value registered at edge k is valid on weightRow at edge k+1, because the RAM reads on the falling edge in between.
- IDLE:
  - On start=1: latch xIn, clear all accumulators, set weightAddr=0, colCnt=0, busy=1, go to RUN.
  - On start=0: hold; done=0.
- RUN, at each rising edge:
  - acc[i] += weightRow[i] * xLatched[colCnt] (signed BITWIDTH×BITWIDTH → 2*BITWIDTH, sign-extended to ACC_W), for all i in parallel.
  - If colCnt<NCOL-1: colCnt++, weightAddr<=colCnt+1.
  - Else go to OUT.
- OUT, one edge:
  - yOut[i] <= sat(acc[i] >>> FRAC). The shift is arithmetic, i.e. truncation toward −∞, with no rounding.
  - sat clamps to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1].
  - done<=1, busy<=0, weightAddr<=0, then IDLE.
- Latency:
  - The accepted start edge is E0.
  - MAC edges are E1..E_NCOL.
  - yOut and done are updated at E_NCOL+1, so done is high in the cycle after edge NCOL+1 (17 cycles for defaults).
- start while busy=1 is ignored: no restart, no queuing.
- Back-to-back operation: done is high while the state is already IDLE, so a start in the done cycle is accepted. Throughput is one multiply per NCOL+2 cycles.
- xIn changes after the accepted start do not affect the result in flight.
- Reset mid-operation aborts immediately:
  - No done pulse is produced.
  - yOut is cleared to 0.
  - The next start computes from scratch.
- weightAddr wraps only through explicit reload to 0; it never exceeds NCOL-1.
- NROW lanes are fully parallel: NROW multipliers and no time-multiplexing.

Test Plan:
- Identity: W diagonal=2048, off-diagonal=0; x[j]=j*2048 → y[i]=i*2048 (y[15]=30720); done exactly 17 cycles after the start edge; busy high for cycles 1–17.
- All-ones: every W=2048, every x=2048 → every y=16*2048=32768; weightAddr sequence 0,1,…,15, then 0.
- Saturation:
  - W=131071, x=131071 → every y=131071.
  - W=−131072, x=131071 → every y=−131072.
- Truncation:
  - W[0][0]=1, x[0]=1, rest 0 → y[0]=0.
  - W[0][0]=−1, x[0]=1 → y[0]=−1 (0x3FFFF).
- Handshake:
  - start pulsed at cycles 3 and 8 of a run → single done, result unchanged.
  - start held high through done → second run accepted immediately, second done 18 cycles after the first.
- Reset mid-run: assert reset at cycle 6 of a run → next cycle yOut=0, busy=0, done=0, weightAddr=0, with no done pulse. Restart with the identity case → correct identity result.
